// File: rtl/iomem_timer_pwm_if.sv
// -----------------------------------------------------------------------------
// iomem_timer_pwm_if
//   picosoc iomem bus bundle for the timer/PWM peripheral.
//
//   valid  master -> slave  request strobe
//   wstrb  master -> slave  byte write strobes, 0 = read
//   addr   master -> slave  byte address
//   wdata  master -> slave  write data
//   ready  slave -> master  one-cycle acknowledge
//   rdata  slave -> master  read data, valid while ready = 1, otherwise 0
// -----------------------------------------------------------------------------
interface iomem_timer_pwm_if;
  logic        valid;
  logic        ready;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output valid, wstrb, addr, wdata, input ready, rdata);
  modport slave  (input valid, wstrb, addr, wdata, output ready, rdata);
endinterface

// File: rtl/iomem_timer_pwm.sv
// -----------------------------------------------------------------------------
// iomem_timer_pwm
//   Memory-mapped down-counter with prescaler, auto-reload, level interrupt
//   and a PWM output compared against the live count.
//
//   Ports
//     clk      clock
//     resetn   synchronous, active-low reset
//     bus      iomem slave (valid/ready/wstrb/addr/wdata/rdata); ready and
//              rdata are 0 when this block is not answering, so the top level
//              can OR them with the other slaves
//     irq      level interrupt: STATUS.expired & CTRL.irq_en
//     pwm_out  CTRL.en & (COUNT < COMPARE)
//
//   Register map (addr[4:2])
//     0 CTRL     bit0 en, bit1 auto_reload, bit2 irq_en
//     1 RELOAD   32-bit reload value
//     2 COUNT    live count; a write loads the counter
//     3 COMPARE  32-bit PWM compare value
//     4 STATUS   bit0 expired, write 1 to clear
//     5..7       read 0, writes ignored, still acknowledged
// -----------------------------------------------------------------------------
module iomem_timer_pwm #(
  parameter logic [7:0]  BASE_PAGE = 8'h04,
  parameter int unsigned PRESCALE  = 1      // clk cycles per tick, 1..65536
) (
  input  logic                clk,
  input  logic                resetn,
  iomem_timer_pwm_if.slave    bus,
  output logic                irq,
  output logic                pwm_out
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  localparam logic [2:0] REG_CTRL    = 3'd0;
  localparam logic [2:0] REG_RELOAD  = 3'd1;
  localparam logic [2:0] REG_COUNT   = 3'd2;
  localparam logic [2:0] REG_COMPARE = 3'd3;
  localparam logic [2:0] REG_STATUS  = 3'd4;

  typedef struct packed {
    logic irq_en;
    logic auto_reload;
    logic en;
  } ctrl_t;

  ctrl_t         ctrl_q,    ctrl_d;
  logic [31:0]   reload_q,  reload_d;
  logic [31:0]   count_q,   count_d;
  logic [31:0]   compare_q, compare_d;
  logic          expired_q, expired_d;
  logic [PW-1:0] presc_q,   presc_d;
  logic          ready_q,   ready_d;
  logic [31:0]   rdata_q,   rdata_d;

  logic          sel;
  logic          wr;
  logic [2:0]    reg_idx;
  logic [31:0]   rd_val;
  logic          tick;
  logic          count_wr;
  logic          expire;
  logic          w1c;

  // Only the page and word-index bits take part in decode.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.addr[23:5], bus.addr[1:0]};

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    ctrl_d    = ctrl_q;
    reload_d  = reload_q;
    count_d   = count_q;
    compare_d = compare_q;
    expired_d = expired_q;
    presc_d   = presc_q;
    count_wr  = 1'b0;
    w1c       = 1'b0;
    expire    = 1'b0;
    rd_val    = '0;

    // Gating on !ready_q makes back-to-back requests answer every other cycle
    // and keeps one request from being acknowledged twice.
    sel     = bus.valid & ~ready_q & (bus.addr[31:24] == BASE_PAGE);
    wr      = sel & (|bus.wstrb);
    reg_idx = bus.addr[4:2];

    // Read mux: pre-write register values.
    case (reg_idx)
      REG_CTRL:    rd_val = {29'd0, ctrl_q};
      REG_RELOAD:  rd_val = reload_q;
      REG_COUNT:   rd_val = count_q;
      REG_COMPARE: rd_val = compare_q;
      REG_STATUS:  rd_val = {31'd0, expired_q};
      default:     rd_val = '0;
    endcase

    if (wr) begin
      case (reg_idx)
        REG_CTRL:    if (bus.wstrb[0]) ctrl_d = ctrl_t'(bus.wdata[2:0]);
        REG_RELOAD:  reload_d  = merge_bytes(reload_q, bus.wdata, bus.wstrb);
        REG_COUNT: begin
          count_d  = merge_bytes(count_q, bus.wdata, bus.wstrb);
          count_wr = 1'b1;
        end
        REG_COMPARE: compare_d = merge_bytes(compare_q, bus.wdata, bus.wstrb);
        REG_STATUS:  w1c = bus.wstrb[0] & bus.wdata[0];
        default: ;
      endcase
    end

    // The prescaler is held at 0 while disabled, so a 0->1 write of en always
    // starts a fresh prescale period.
    tick = ctrl_q.en & (presc_q == PRESC_LAST);
    if (!ctrl_q.en || tick) presc_d = '0;
    else                    presc_d = presc_q + PW'(1);

    // A bus write to COUNT takes priority over the tick entirely.
    if (tick && !count_wr) begin
      if (count_q != 32'd0) begin
        count_d = count_q - 32'd1;
      end else begin
        expire = 1'b1;
        if (ctrl_q.auto_reload) count_d   = reload_q;
        else                    ctrl_d.en = 1'b0;
      end
    end

    // Set beats clear when both land on the same edge.
    if (w1c)    expired_d = 1'b0;
    if (expire) expired_d = 1'b1;

    ready_d = sel;
    rdata_d = sel ? rd_val : '0;
  end

  // NOTE: the reset is sampled on the clock edge (synchronous), matching the
  // rest of the SoC, so it lives inside the clocked branch, not the sensitivity
  // list.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ctrl_q    <= '0;
      reload_q  <= '0;
      count_q   <= '0;
      compare_q <= '0;
      expired_q <= 1'b0;
      presc_q   <= '0;
      ready_q   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed above, independent of statement order.
      ctrl_q    <= ctrl_d;
      reload_q  <= reload_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      expired_q <= expired_d;
      presc_q   <= presc_d;
      ready_q   <= ready_d;
      rdata_q   <= rdata_d;
    end
  end

  assign bus.ready = ready_q;
  assign bus.rdata = rdata_q;
  assign irq       = expired_q & ctrl_q.irq_en;
  assign pwm_out   = ctrl_q.en & (count_q < compare_q);

endmodule

// File: tb/tb_iomem_timer_pwm.sv
// -----------------------------------------------------------------------------
// tb_iomem_timer_pwm
//   Directed bench for iomem_timer_pwm (BASE_PAGE 8'h04, PRESCALE 1).
//   Inputs change #1 after the rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_iomem_timer_pwm;

  localparam logic [31:0] A_CTRL    = 32'h0400_0000;
  localparam logic [31:0] A_RELOAD  = 32'h0400_0004;
  localparam logic [31:0] A_COUNT   = 32'h0400_0008;
  localparam logic [31:0] A_COMPARE = 32'h0400_000C;
  localparam logic [31:0] A_STATUS  = 32'h0400_0010;

  logic clk;
  logic resetn;
  logic irq;
  logic pwm_out;

  int n_checks = 0;
  int n_errors = 0;

  iomem_timer_pwm_if bus ();

  iomem_timer_pwm #(
    .BASE_PAGE (8'h04),
    .PRESCALE  (1)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .bus     (bus),
    .irq     (irq),
    .pwm_out (pwm_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One bus access; returns #1 after the acknowledging edge with ready high.
  task automatic bus_xfer(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, output logic [31:0] rdata,
                          output int lat);
    bus.valid = 1'b1;
    bus.addr  = addr;
    bus.wdata = wdata;
    bus.wstrb = strb;
    lat   = 0;
    rdata = '0;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (bus.ready) begin
        lat   = i;
        rdata = bus.rdata;
        break;
      end
    end
    bus.valid = 1'b0;
    bus.wstrb = 4'h0;
    if (lat == 0) check("bus_timeout", 32'(lat), 32'd1);
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb = 4'hF);
    logic [31:0] dummy;
    int          lat;
    bus_xfer(addr, wdata, strb, dummy, lat);
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] rdata);
    int lat;
    bus_xfer(addr, 32'd0, 4'h0, rdata, lat);
  endtask

  logic [31:0] rd;
  int          lat;
  int          high_cnt;
  int          ready_seen;
  int          rdata_seen;
  logic [31:0] exp_cnt [4] = '{32'd2, 32'd1, 32'd0, 32'd3};
  logic        exp_irq [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    bus.valid = 1'b0;
    bus.wstrb = 4'h0;
    bus.addr  = '0;
    bus.wdata = '0;
    resetn    = 1'b0;
    repeat (3) step();
    resetn = 1'b1;

    // ---- 1: reset state and reads of every register -----------------------
    check("rst_ready", 32'(bus.ready), 32'd0);
    check("rst_rdata", bus.rdata, 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_pwm", 32'(pwm_out), 32'd0);
    for (int k = 0; k < 5; k++) begin
      step();
      bus_xfer(A_CTRL + 32'(4 * k), 32'd0, 4'h0, rd, lat);
      check($sformatf("rst_lat_%0d", k), 32'(lat), 32'd1);
      check($sformatf("rst_read_%0d", k), rd, 32'd0);
    end
    step();
    check("ready_one_cycle", 32'(bus.ready), 32'd0);
    check("rdata_idle_zero", bus.rdata, 32'd0);

    // ---- 2: auto-reload, PRESCALE 1 ---------------------------------------
    bus_write(A_RELOAD, 32'd3);
    bus_write(A_COUNT, 32'd3);
    bus_write(A_CTRL, 32'h7);
    check("ar_cnt_start", dut.count_q, 32'd3);
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("ar_cnt_%0d", i), dut.count_q, exp_cnt[i]);
      check($sformatf("ar_irq_%0d", i), 32'(irq), 32'(exp_irq[i]));
    end
    bus_write(A_STATUS, 32'd1);            // lands on the tick 3 -> 2
    check("w1c_irq", 32'(irq), 32'd0);
    check("w1c_cnt", dut.count_q, 32'd2);
    step();
    check("ar2_irq_a", 32'(irq), 32'd0);
    step();
    check("ar2_irq_b", 32'(irq), 32'd0);
    step();                                 // 4 clks after the first expiry
    check("ar2_irq_c", 32'(irq), 32'd1);
    check("ar2_cnt", dut.count_q, 32'd3);
    bus_write(A_STATUS, 32'd1);
    check("w1c2_irq", 32'(irq), 32'd0);
    bus_write(A_CTRL, 32'h0);

    // ---- 3: one-shot ------------------------------------------------------
    bus_write(A_STATUS, 32'd1);
    bus_write(A_COUNT, 32'd2);
    bus_write(A_CTRL, 32'h1);
    step();
    check("os_exp_1", 32'(dut.expired_q), 32'd0);
    step();
    check("os_exp_2", 32'(dut.expired_q), 32'd0);
    step();
    check("os_exp_3", 32'(dut.expired_q), 32'd1);
    bus_read(A_CTRL, rd);
    check("os_ctrl", rd, 32'd0);
    bus_read(A_COUNT, rd);
    check("os_count", rd, 32'd0);
    bus_read(A_STATUS, rd);
    check("os_status", rd, 32'd1);
    check("os_irq", 32'(irq), 32'd0);

    // ---- 4: PWM -----------------------------------------------------------
    bus_write(A_RELOAD, 32'd9);
    bus_write(A_COMPARE, 32'd4);
    bus_write(A_COUNT, 32'd2);
    check("pwm_off_en0", 32'(pwm_out), 32'd0);
    bus_write(A_COUNT, 32'd9);
    bus_write(A_CTRL, 32'h3);
    high_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (pwm_out) high_cnt++;
      step();
    end
    check("pwm_duty", 32'(high_cnt), 32'd8);
    bus_write(A_CTRL, 32'h0);
    check("pwm_off_stop", 32'(pwm_out), 32'd0);

    // ---- 5: collisions on the expiry edge ---------------------------------
    bus_write(A_STATUS, 32'd1);
    bus_write(A_RELOAD, 32'd3);
    bus_write(A_COUNT, 32'd1);
    bus_write(A_CTRL, 32'h7);
    bus_write(A_COUNT, 32'd100);            // acked on the count==0 tick
    check("col_cnt_wr", dut.count_q, 32'd100);
    check("col_cnt_irq", 32'(irq), 32'd0);
    bus_write(A_CTRL, 32'h0);
    bus_read(A_STATUS, rd);
    check("col_cnt_status", rd, 32'd0);

    bus_write(A_COUNT, 32'd1);
    bus_write(A_CTRL, 32'h7);
    bus_write(A_STATUS, 32'd1);             // W1C on the expiry edge
    check("col_w1c_irq", 32'(irq), 32'd1);
    check("col_w1c_cnt", dut.count_q, 32'd3);
    bus_write(A_CTRL, 32'h0);

    bus_write(A_STATUS, 32'd1);
    bus_write(A_COUNT, 32'd1);
    bus_write(A_CTRL, 32'h7);
    bus_write(A_CTRL, 32'h4);               // clear en on the expiry edge
    check("col_en_irq", 32'(irq), 32'd1);
    check("col_en_en", 32'(dut.ctrl_q[0]), 32'd0);

    // ---- 6: byte strobes and decode ---------------------------------------
    bus_write(A_RELOAD, 32'd0);
    bus_write(A_RELOAD, 32'hAABB_CCDD, 4'b0010);
    bus_read(A_RELOAD, rd);
    check("strb_reload", rd, 32'h0000_CC00);

    step();
    bus.valid  = 1'b1;
    bus.addr   = 32'h0300_0000;
    bus.wstrb  = 4'h0;
    ready_seen = 0;
    rdata_seen = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus.ready) ready_seen++;
      if (bus.rdata != 32'd0) rdata_seen++;
    end
    bus.valid = 1'b0;
    check("page3_ready", 32'(ready_seen), 32'd0);
    check("page3_rdata", 32'(rdata_seen), 32'd0);

    bus_write(32'h0400_001C, 32'hFFFF_FFFF);
    bus_xfer(32'h0400_001C, 32'd0, 4'h0, rd, lat);
    check("off1c_ack", 32'(lat != 0), 32'd1);
    check("off1c_rdata", rd, 32'd0);

    // ---- reset with a request and a running PWM in flight ------------------
    bus_write(A_COMPARE, 32'hFFFF_FFFF);
    bus_write(A_COUNT, 32'd50);
    bus_write(A_CTRL, 32'h1);
    check("pre_rst_pwm", 32'(pwm_out), 32'd1);
    step();
    bus.valid = 1'b1;
    bus.addr  = A_COUNT;
    resetn    = 1'b0;
    step();
    check("mid_rst_ready", 32'(bus.ready), 32'd0);
    check("mid_rst_pwm", 32'(pwm_out), 32'd0);
    check("mid_rst_cnt", dut.count_q, 32'd0);
    bus.valid = 1'b0;
    resetn    = 1'b1;
    step();
    check("post_rst_ready", 32'(bus.ready), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
